// File: rtl/exception_sequencer_pkg.sv
// Shared constants for the exception sequencer: CP0 exception codes, request flag bit
// positions, FSM state encoding and the interrupt-pending test.
package exception_sequencer_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam int FLAG_SYSCALL = 0;
    localparam int FLAG_INVALID = 1;
    localparam int FLAG_TRAP    = 2;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_ERET    = 4;
    localparam int FLAG_COUNT   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // Status[0]=IE, Status[1]=EXL, IM/IP masks live in bits [15:8] of Status/Cause.
    function automatic logic interrupt_pending(input logic [31:0] status,
                                               input logic [31:0] cause);
        return (|(cause[15:8] & status[15:8])) && status[0] && !status[1];
    endfunction

endpackage

// File: rtl/exception_sequencer_priority_encoder.sv
// Combinational event selection: picks the single highest-priority event of the
// retiring instruction (interrupt > syscall > invalid > trap > overflow > eret).
module exception_priority_encoder
    import exception_sequencer_pkg::*;
(
    input  logic                  valid,
    input  logic [FLAG_COUNT-1:0] flags,
    input  logic [31:0]           status,
    input  logic [31:0]           cause,
    output logic                  event_valid,
    output logic [31:0]           event_code
);

    logic irq;

    assign irq = interrupt_pending(status, cause);

    always_comb begin
        // NOTE: every output gets a default first so no path through the chain infers a latch.
        event_valid = 1'b0;
        event_code  = EXC_NONE;
        if (valid) begin
            event_valid = 1'b1;
            if (irq)                         event_code = EXC_INT;
            else if (flags[FLAG_SYSCALL])    event_code = EXC_SYS;
            else if (flags[FLAG_INVALID])    event_code = EXC_INV;
            else if (flags[FLAG_TRAP])       event_code = EXC_TRAP;
            else if (flags[FLAG_OVERFLOW])   event_code = EXC_OV;
            else if (flags[FLAG_ERET])       event_code = EXC_ERET;
            else                             event_valid = 1'b0;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception/ERET entry sequencer at the mem/wb boundary: issues one CP0 code for a
// single cycle, then holds the pipeline flush while fetch is redirected.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  request_valid_input,
    input  logic [FLAG_COUNT-1:0] request_flags_input,
    input  logic [31:0]           current_instruction_address_input,
    input  logic                  is_in_delay_slot_input,
    input  logic [31:0]           status_input,
    input  logic [31:0]           cause_input,
    input  logic [31:0]           epc_input,
    output logic [31:0]           exception_type_output,
    output logic [31:0]           current_instruction_address_output,
    output logic                  is_in_delay_slot_output,
    output logic                  flush_output,
    output logic [31:0]           new_pc_output,
    output logic                  busy_output
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] flush_count;
    logic             event_valid;
    logic [31:0]      event_code;

    exception_priority_encoder u_priority (
        .valid       (request_valid_input),
        .flags       (request_flags_input),
        .status      (status_input),
        .cause       (cause_input),
        .event_valid (event_valid),
        .event_code  (event_code)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state                              <= ST_IDLE;
            flush_count                        <= '0;
            exception_type_output              <= EXC_NONE;
            current_instruction_address_output <= '0;
            is_in_delay_slot_output            <= 1'b0;
            flush_output                       <= 1'b0;
            new_pc_output                      <= '0;
            busy_output                        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (event_valid) begin
                        state                              <= ST_ISSUE;
                        exception_type_output              <= event_code;
                        current_instruction_address_output <= current_instruction_address_input;
                        is_in_delay_slot_output            <= is_in_delay_slot_input;
                        flush_output                       <= 1'b1;
                        new_pc_output                      <= (event_code == EXC_ERET) ?
                                                              epc_input : EXCEPTION_VECTOR;
                        busy_output                        <= 1'b1;
                    end else begin
                        exception_type_output              <= EXC_NONE;
                        current_instruction_address_output <= '0;
                        is_in_delay_slot_output            <= 1'b0;
                        flush_output                       <= 1'b0;
                        new_pc_output                      <= '0;
                        busy_output                        <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    // The code is dropped after one cycle so CP0 records the event once.
                    exception_type_output              <= EXC_NONE;
                    current_instruction_address_output <= '0;
                    is_in_delay_slot_output            <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state       <= ST_FLUSH;
                        flush_count <= FLUSH_LOAD;
                    end else begin
                        state         <= ST_IDLE;
                        flush_output  <= 1'b0;
                        new_pc_output <= '0;
                        busy_output   <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    if (flush_count <= CNT_ONE) begin
                        state         <= ST_IDLE;
                        flush_count   <= '0;
                        flush_output  <= 1'b0;
                        new_pc_output <= '0;
                        busy_output   <= 1'b0;
                    end else begin
                        flush_count <= flush_count - CNT_ONE;
                    end
                end

                default: begin
                    state                              <= ST_IDLE;
                    flush_count                        <= '0;
                    exception_type_output              <= EXC_NONE;
                    current_instruction_address_output <= '0;
                    is_in_delay_slot_output            <= 1'b0;
                    flush_output                       <= 1'b0;
                    new_pc_output                      <= '0;
                    busy_output                        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: one instance with FLUSH_CYCLES=2 and one with 1.
module tb_exception_sequencer;

    logic        clock;
    logic        reset;
    logic        valid;
    logic [4:0]  flags;
    logic [31:0] pc;
    logic        delay;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    logic [31:0] type0, addr0, npc0;
    logic        ds0, flush0, busy0;
    logic [31:0] type1, addr1, npc1;
    logic        ds1, flush1, busy1;

    int checks = 0;
    int errors = 0;

    exception_sequencer #(.EXCEPTION_VECTOR(32'h20), .FLUSH_CYCLES(2)) dut (
        .clock                              (clock),
        .reset                              (reset),
        .request_valid_input                (valid),
        .request_flags_input                (flags),
        .current_instruction_address_input  (pc),
        .is_in_delay_slot_input             (delay),
        .status_input                       (status),
        .cause_input                        (cause),
        .epc_input                          (epc),
        .exception_type_output              (type0),
        .current_instruction_address_output (addr0),
        .is_in_delay_slot_output            (ds0),
        .flush_output                       (flush0),
        .new_pc_output                      (npc0),
        .busy_output                        (busy0)
    );

    exception_sequencer #(.EXCEPTION_VECTOR(32'h20), .FLUSH_CYCLES(1)) dut_one (
        .clock                              (clock),
        .reset                              (reset),
        .request_valid_input                (valid),
        .request_flags_input                (flags),
        .current_instruction_address_input  (pc),
        .is_in_delay_slot_input             (delay),
        .status_input                       (status),
        .cause_input                        (cause),
        .epc_input                          (epc),
        .exception_type_output              (type1),
        .current_instruction_address_output (addr1),
        .is_in_delay_slot_output            (ds1),
        .flush_output                       (flush1),
        .new_pc_output                      (npc1),
        .busy_output                        (busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        valid  = 1'b0;
        flags  = 5'b0;
        pc     = 32'h0;
        delay  = 1'b0;
        status = 32'h0;
        cause  = 32'h0;
        epc    = 32'h0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".type"},  type0,  32'h0);
        check({tag, ".addr"},  addr0,  32'h0);
        check({tag, ".ds"},    32'(ds0),    32'h0);
        check({tag, ".flush"}, 32'(flush0), 32'h0);
        check({tag, ".npc"},   npc0,   32'h0);
        check({tag, ".busy"},  32'(busy0),  32'h0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        check_quiet("reset");
        reset = 1'b1;
        step();
        check_quiet("idle");

        // 1: syscall, 2-cycle flush
        valid = 1'b1; flags = 5'b00001; pc = 32'h100;
        step();
        idle_inputs();
        check("t1.type",  type0, 32'h8);
        check("t1.addr",  addr0, 32'h100);
        check("t1.flush", 32'(flush0), 32'h1);
        check("t1.npc",   npc0,  32'h20);
        check("t1.busy",  32'(busy0), 32'h1);
        step();
        check("t1.type2",  type0, 32'h0);
        check("t1.addr2",  addr0, 32'h0);
        check("t1.flush2", 32'(flush0), 32'h1);
        check("t1.npc2",   npc0,  32'h20);
        check("t1.busy2",  32'(busy0), 32'h1);
        step();
        check_quiet("t1.end");

        // 2: interrupt beats overflow
        valid = 1'b1; flags = 5'b01000; delay = 1'b1; pc = 32'h204;
        status = 32'h0000_0401; cause = 32'h0000_0400;
        step();
        idle_inputs();
        check("t2.type", type0, 32'h1);
        check("t2.addr", addr0, 32'h204);
        check("t2.ds",   32'(ds0), 32'h1);
        check("t2.npc",  npc0,  32'h20);
        step();
        check("t2.ds2",  32'(ds0), 32'h0);
        step();

        // interrupt pending but no valid instruction: no event
        status = 32'h0000_0401; cause = 32'h0000_0400; flags = 5'b00001;
        step();
        idle_inputs();
        check("t2b.flush", 32'(flush0), 32'h0);
        check("t2b.busy",  32'(busy0),  32'h0);

        // 3: eret targets EPC
        valid = 1'b1; flags = 5'b10000; epc = 32'h3000; pc = 32'h400;
        step();
        idle_inputs();
        check("t3.type", type0, 32'he);
        check("t3.npc",  npc0,  32'h3000);
        step();
        check("t3.npc2", npc0,  32'h3000);
        step();

        // 3b: EXL=1 masks the pending interrupt, eret still wins
        valid = 1'b1; flags = 5'b10000; epc = 32'h4000;
        status = 32'h0000_0403; cause = 32'h0000_0400;
        step();
        idle_inputs();
        check("t3b.type", type0, 32'he);
        check("t3b.npc",  npc0,  32'h4000);
        step();
        step();

        // 4: syscall held high; ignored in FLUSH, re-issued after IDLE
        valid = 1'b1; flags = 5'b00001; pc = 32'h300;
        step();
        check("t4.type1", type0, 32'h8);
        step();
        check("t4.flushst", type0, 32'h0);
        check("t4.flush",   32'(flush0), 32'h1);
        step();
        check("t4.idle.flush", 32'(flush0), 32'h0);
        check("t4.idle.type",  type0, 32'h0);
        step();
        check("t4.type2", type0, 32'h8);
        check("t4.addr2", addr0, 32'h300);
        idle_inputs();
        step();
        step();

        // 5: reset during ISSUE aborts, then a new event is accepted
        valid = 1'b1; flags = 5'b00100; pc = 32'h500;
        step();
        check("t5.type", type0, 32'hd);
        idle_inputs();
        reset = 1'b0;
        step();
        check_quiet("t5.rst");
        reset = 1'b1;
        step();
        check_quiet("t5.post");
        valid = 1'b1; flags = 5'b00010; pc = 32'h600;
        step();
        idle_inputs();
        check("t5.type2", type0, 32'ha);
        check("t5.addr2", addr0, 32'h600);
        check("t5.busy2", 32'(busy0), 32'h1);
        step();
        step();
        step();

        // 6: FLUSH_CYCLES=1 instance, IE gating then single-cycle flush
        valid = 1'b1; status = 32'h0000_0400; cause = 32'h0000_0400;
        step();
        check("t6.noie.flush", 32'(flush1), 32'h0);
        check("t6.noie.busy",  32'(busy1),  32'h0);
        status = 32'h0000_0401;
        step();
        idle_inputs();
        check("t6.type",  type1, 32'h1);
        check("t6.flush", 32'(flush1), 32'h1);
        check("t6.npc",   npc1,  32'h20);
        check("t6.busy",  32'(busy1), 32'h1);
        step();
        check("t6.flush2", 32'(flush1), 32'h0);
        check("t6.busy2",  32'(busy1),  32'h0);
        check("t6.type2",  type1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
